// File: rtl/serial_pattern_feeder_if.sv
// Word-in / bit-out handshake bundle for serial_pattern_feeder.
// master = word producer, slave = the serialiser.
interface serial_pattern_feeder_if #(
    parameter int WIDTH = 8
) ();
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             bit_out;
    logic             bit_valid;
    logic             last_bit;
    logic             busy;

    modport master (
        output din,
        output din_valid,
        input  din_ready,
        input  bit_out,
        input  bit_valid,
        input  last_bit,
        input  busy
    );

    modport slave (
        input  din,
        input  din_valid,
        output din_ready,
        output bit_out,
        output bit_valid,
        output last_bit,
        output busy
    );
endinterface

// File: rtl/serial_pattern_feeder.sv
// Parallel-to-serial feeder for the bit-serial sequence detector.
// Back-to-back words stream with no gap bit between them.
module serial_pattern_feeder #(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input logic                  clk,
    input logic                  rst,
    serial_pattern_feeder_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_nxt;
    logic             bit_q;
    logic             valid_q;
    logic             last_q;
    logic             busy_q;
    logic             ready;
    logic             xfer;

    // Bit that leaves the register first, selected by shift direction.
    function automatic logic head(input logic [WIDTH-1:0] s);
        return MSB_FIRST ? s[WIDTH-1] : s[0];
    endfunction

    // One-position shift toward the output end.
    function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] s);
        return MSB_FIRST ? {s[WIDTH-2:0], 1'b0} : {1'b0, s[WIDTH-1:1]};
    endfunction

    // Ready comes from state only, so a new word lands on the last-bit edge.
    assign ready = !rst && (state == IDLE || cnt == LAST);
    assign xfer  = ready && bus.din_valid;

    assign bus.din_ready = ready;
    assign bus.bit_out   = bit_q;
    assign bus.bit_valid = valid_q;
    assign bus.last_bit  = last_q;
    assign bus.busy      = busy_q;

    // Next-state, counter and shift-register decode.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sreg_nxt  = sreg;
        unique case (state)
            IDLE: begin
                if (xfer) begin
                    sreg_nxt  = bus.din;
                    cnt_nxt   = '0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt != LAST) begin
                    sreg_nxt = step(sreg);
                    cnt_nxt  = cnt + 1'b1;
                end else if (xfer) begin
                    sreg_nxt = bus.din;
                    cnt_nxt  = '0;
                end else begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    // State registers plus outputs registered from the next-state values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            sreg    <= '0;
            bit_q   <= IDLE_LEVEL;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            sreg    <= sreg_nxt;
            bit_q   <= (state_nxt == SHIFT) ? head(sreg_nxt) : IDLE_LEVEL;
            valid_q <= (state_nxt == SHIFT);
            busy_q  <= (state_nxt == SHIFT);
            last_q  <= (state_nxt == SHIFT) && (cnt_nxt == LAST);
        end
    end
endmodule

// File: tb/tb_serial_pattern_feeder.sv
// Directed bench for serial_pattern_feeder: MSB-first and LSB-first
// instances, with a small 1101 detector model on the MSB-first stream.
module tb_serial_pattern_feeder;
    logic clk;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [3:0]  hist = 4'b0000;
    int          det_cnt = 0;
    int          d0;
    logic [15:0] pat;

    serial_pattern_feeder_if #(.WIDTH(8)) bus_msb ();
    serial_pattern_feeder_if #(.WIDTH(8)) bus_lsb ();

    serial_pattern_feeder #(
        .WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)
    ) u_msb (
        .clk(clk), .rst(rst), .bus(bus_msb)
    );

    serial_pattern_feeder #(
        .WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)
    ) u_lsb (
        .clk(clk), .rst(rst), .bus(bus_lsb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Overlapping 1101 detector fed every cycle from the serial stream.
    always @(posedge clk) begin
        hist <= {hist[2:0], bus_msb.bit_out};
        if ({hist[2:0], bus_msb.bit_out} == 4'b1101)
            det_cnt <= det_cnt + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus_msb.din = 8'h00;
        bus_msb.din_valid = 1'b0;
        bus_lsb.din = 8'h00;
        bus_lsb.din_valid = 1'b0;
        tick;
        tick;
        chk("rst_ready_low", bus_msb.din_ready, 1'b0);
        rst = 1'b0;
        #1;
        chk("rst_bit_out", bus_msb.bit_out, 1'b0);
        chk("rst_bit_valid", bus_msb.bit_valid, 1'b0);
        chk("rst_last_bit", bus_msb.last_bit, 1'b0);
        chk("rst_busy", bus_msb.busy, 1'b0);
        chk("rst_ready_idle", bus_msb.din_ready, 1'b1);
        tick;

        // Single word D0, din scrambled while busy.
        d0 = det_cnt;
        bus_msb.din = 8'hD0;
        bus_msb.din_valid = 1'b1;
        tick;
        bus_msb.din_valid = 1'b0;
        bus_msb.din = 8'hA5;
        pat = 16'hD000;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t1_bit%0d", i), bus_msb.bit_out, pat[15-i]);
            chk($sformatf("t1_valid%0d", i), bus_msb.bit_valid, 1'b1);
            chk($sformatf("t1_last%0d", i), bus_msb.last_bit, i == 7);
            tick;
        end
        chk("t1_valid_after", bus_msb.bit_valid, 1'b0);
        chk("t1_busy_after", bus_msb.busy, 1'b0);
        chk("t1_detect", det_cnt - d0, 1);
        tick;

        // Back-to-back 03 then 40, boundary-spanning 1101.
        d0 = det_cnt;
        bus_msb.din = 8'h03;
        bus_msb.din_valid = 1'b1;
        tick;
        bus_msb.din = 8'h40;
        pat = 16'h0340;
        for (int i = 1; i <= 16; i++) begin
            chk($sformatf("t2_bit%0d", i), bus_msb.bit_out, pat[16-i]);
            chk($sformatf("t2_valid%0d", i), bus_msb.bit_valid, 1'b1);
            chk($sformatf("t2_ready%0d", i), bus_msb.din_ready,
                (i == 8) || (i == 16));
            if (i == 16) bus_msb.din_valid = 1'b0;
            tick;
        end
        chk("t2_valid_after", bus_msb.bit_valid, 1'b0);
        chk("t2_detect", det_cnt - d0, 1);
        tick;

        // Busy hold-off: FF offered during bit 3 of D0.
        bus_msb.din = 8'hD0;
        bus_msb.din_valid = 1'b1;
        tick;
        bus_msb.din_valid = 1'b0;
        pat = 16'hD0FF;
        for (int i = 1; i <= 16; i++) begin
            if (i == 2) bus_msb.din = 8'h55;
            if (i == 3) begin
                bus_msb.din = 8'hFF;
                bus_msb.din_valid = 1'b1;
            end
            chk($sformatf("t3_bit%0d", i), bus_msb.bit_out, pat[16-i]);
            chk($sformatf("t3_ready%0d", i), bus_msb.din_ready,
                (i == 8) || (i == 16));
            chk($sformatf("t3_last%0d", i), bus_msb.last_bit,
                (i == 8) || (i == 16));
            if (i == 16) bus_msb.din_valid = 1'b0;
            tick;
        end
        chk("t3_busy_after", bus_msb.busy, 1'b0);
        tick;

        // LSB-first instance with 0B.
        bus_lsb.din = 8'h0B;
        bus_lsb.din_valid = 1'b1;
        tick;
        bus_lsb.din_valid = 1'b0;
        pat = 16'hD000;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t4_bit%0d", i), bus_lsb.bit_out, pat[15-i]);
            chk($sformatf("t4_valid%0d", i), bus_lsb.bit_valid, 1'b1);
            chk($sformatf("t4_last%0d", i), bus_lsb.last_bit, i == 7);
            tick;
        end
        chk("t4_valid_after", bus_lsb.bit_valid, 1'b0);
        tick;

        // Reset during bit 3 of D0, FF offered in the reset cycle.
        bus_msb.din = 8'hD0;
        bus_msb.din_valid = 1'b1;
        tick;
        bus_msb.din_valid = 1'b0;
        chk("t5_bit1", bus_msb.bit_out, 1'b1);
        tick;
        chk("t5_bit2", bus_msb.bit_out, 1'b1);
        tick;
        chk("t5_bit3", bus_msb.bit_out, 1'b0);
        rst = 1'b1;
        bus_msb.din = 8'hFF;
        bus_msb.din_valid = 1'b1;
        #1;
        chk("t5_ready_in_rst", bus_msb.din_ready, 1'b0);
        tick;
        rst = 1'b0;
        bus_msb.din = 8'hB0;
        #1;
        chk("t5_bit_out", bus_msb.bit_out, 1'b0);
        chk("t5_bit_valid", bus_msb.bit_valid, 1'b0);
        chk("t5_busy", bus_msb.busy, 1'b0);
        chk("t5_last_bit", bus_msb.last_bit, 1'b0);
        chk("t5_ready_after", bus_msb.din_ready, 1'b1);
        tick;
        bus_msb.din_valid = 1'b0;
        pat = 16'hB000;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t5_new%0d", i), bus_msb.bit_out, pat[15-i]);
            chk($sformatf("t5_nvalid%0d", i), bus_msb.bit_valid, 1'b1);
            tick;
        end
        chk("t5_valid_after", bus_msb.bit_valid, 1'b0);
        tick;

        // Gapped stream: 0D, two idle cycles, then 00.
        bus_msb.din = 8'h0D;
        bus_msb.din_valid = 1'b1;
        tick;
        bus_msb.din_valid = 1'b0;
        pat = 16'h0D00;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t6_bit%0d", i), bus_msb.bit_out, pat[15-i]);
            chk($sformatf("t6_valid%0d", i), bus_msb.bit_valid, 1'b1);
            tick;
        end
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("t6_idle_bit%0d", i), bus_msb.bit_out, 1'b0);
            chk($sformatf("t6_idle_valid%0d", i), bus_msb.bit_valid, 1'b0);
            chk($sformatf("t6_idle_ready%0d", i), bus_msb.din_ready, 1'b1);
            if (i == 1) begin
                bus_msb.din = 8'h00;
                bus_msb.din_valid = 1'b1;
            end
            tick;
        end
        bus_msb.din_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t6_zero%0d", i), bus_msb.bit_out, 1'b0);
            chk($sformatf("t6_zvalid%0d", i), bus_msb.bit_valid, 1'b1);
            chk($sformatf("t6_zlast%0d", i), bus_msb.last_bit, i == 7);
            tick;
        end
        chk("t6_valid_after", bus_msb.bit_valid, 1'b0);
        chk("t6_ready_after", bus_msb.din_ready, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
